watchdog_timer: RTL and testbench

WATCHDOG_TIMER -- requirements
Module: watchdog_timer

---
 rtl/watchdog_timer.sv | 149 ++++++++++++++
 tb/tb_watchdog_timer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_timer.sv
// Watchdog timer: an 8 Hz countdown reloaded by kick; on expiry it issues a
// reset pulse of PULSE_LEN 32 kHz ticks and sets a sticky expired flag.
module watchdog_timer #(
  parameter logic [7:0] PULSE_LEN = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_32khz,
  input  logic       ce_8hz,
  input  logic       cfg_we,
  input  logic       cfg_en,
  input  logic       cfg_lock,
  input  logic [7:0] cfg_timeout,
  input  logic       kick,
  input  logic       clr_expired,
  output logic [7:0] count,
  output logic       wdt_rst,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PULSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       en_q, en_d;
  logic       locked_q, locked_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       wdt_rst_q, wdt_rst_d;
  logic       expired_q, expired_d;
  logic       expire;

  // Once locked, a write can only raise en; lock itself is sticky until rst_n.
  always_comb begin
    en_d     = en_q;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    if (cfg_we) begin
      tmo_d = cfg_timeout;
      if (locked_q) begin
        en_d = en_q | cfg_en;
      end else begin
        en_d     = cfg_en;
        locked_d = cfg_lock;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    wdt_rst_d = wdt_rst_q;
    expire    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = 8'd0;
        wdt_rst_d = 1'b0;
        if (en_q) begin
          state_d = COUNT;
          cnt_d   = tmo_q;
        end
      end
      COUNT: begin
        wdt_rst_d = 1'b0;
        if (!en_q) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (kick) begin
          cnt_d = tmo_q;
        end else if (ce_8hz) begin
          // A count of 0 or 1 means this tick is the last one.
          if (cnt_q >= 8'd2) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            expire    = 1'b1;
            state_d   = PULSE;
            wdt_rst_d = 1'b1;
            pcnt_d    = PULSE_LEN;
            cnt_d     = 8'd0;
          end
        end
      end
      PULSE: begin
        wdt_rst_d = 1'b1;
        if (ce_32khz) begin
          if (pcnt_q <= 8'd1) begin
            wdt_rst_d = 1'b0;
            if (en_q) begin
              state_d = COUNT;
              cnt_d   = tmo_q;
            end else begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end
          end else begin
            pcnt_d = pcnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        wdt_rst_d = 1'b0;
      end
    endcase
  end

  // A coincident expiry beats a clear request.
  always_comb begin
    expired_d = expired_q;
    if (expire) begin
      expired_d = 1'b1;
    end else if (clr_expired) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      locked_q  <= 1'b0;
      tmo_q     <= 8'd0;
      cnt_q     <= 8'd0;
      pcnt_q    <= 8'd0;
      wdt_rst_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      locked_q  <= locked_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      wdt_rst_q <= wdt_rst_d;
      expired_q <= expired_d;
    end
  end

  assign count   = cnt_q;
  assign wdt_rst = wdt_rst_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Bench for watchdog_timer: directed vector table, hand sequences for lock and
// asynchronous reset, and randomized traffic checked against a reference model.
module tb_watchdog_timer;

  localparam logic [7:0] PL = 8'd4;

  logic       clk;
  logic       rst_n;
  logic       ce_32khz, ce_8hz, cfg_we, cfg_en, cfg_lock, kick, clr_expired;
  logic [7:0] cfg_timeout;
  logic [7:0] count;
  logic       wdt_rst, expired;

  watchdog_timer #(.PULSE_LEN(PL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce_32khz    (ce_32khz),
    .ce_8hz      (ce_8hz),
    .cfg_we      (cfg_we),
    .cfg_en      (cfg_en),
    .cfg_lock    (cfg_lock),
    .cfg_timeout (cfg_timeout),
    .kick        (kick),
    .clr_expired (clr_expired),
    .count       (count),
    .wdt_rst     (wdt_rst),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    bit       en;
    bit       lk;
    bit [7:0] tmo;
    bit       kick;
    bit       ce8;
    bit       ce32;
    bit       clr;
  } stim_t;

  typedef struct {
    stim_t    s;
    bit [7:0] ec;
    bit       ew;
    bit       ee;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: "armed" countdown of remaining 8 Hz ticks, and a pulse
  // budget of remaining 32 kHz ticks (nonzero means the reset is asserted).
  bit m_en, m_lock, m_armed, m_expired;
  int m_tmo, m_remaining, m_pulse_left;

  function automatic void model_reset();
    m_en = 0; m_lock = 0; m_armed = 0; m_expired = 0;
    m_tmo = 0; m_remaining = 0; m_pulse_left = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    bit fire;
    fire = 0;
    if (m_pulse_left > 0) begin
      if (s.ce32) begin
        if (m_pulse_left == 1) begin
          m_pulse_left = 0;
          m_armed      = m_en;
          m_remaining  = m_en ? m_tmo : 0;
        end else begin
          m_pulse_left = m_pulse_left - 1;
        end
      end
    end else if (m_armed) begin
      if (!m_en) begin
        m_armed = 0;
        m_remaining = 0;
      end else if (s.kick) begin
        m_remaining = m_tmo;
      end else if (s.ce8) begin
        if (m_remaining > 1) begin
          m_remaining = m_remaining - 1;
        end else begin
          fire = 1;
          m_armed = 0;
          m_remaining = 0;
          m_pulse_left = int'(PL);
        end
      end
    end else if (m_en) begin
      m_armed = 1;
      m_remaining = m_tmo;
    end
    if (fire) m_expired = 1;
    else if (s.clr) m_expired = 0;
    if (s.we) begin
      m_tmo = int'(s.tmo);
      if (m_lock) begin
        m_en = m_en | s.en;
      end else begin
        m_en = s.en;
        m_lock = s.lk;
      end
    end
  endfunction

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void add(input bit we, input bit en, input bit lk, input bit [7:0] tmo,
                              input bit k, input bit c8, input bit c32, input bit clr,
                              input bit [7:0] ec, input bit ew, input bit ee);
    vec_t v;
    v.s.we = we; v.s.en = en; v.s.lk = lk; v.s.tmo = tmo;
    v.s.kick = k; v.s.ce8 = c8; v.s.ce32 = c32; v.s.clr = clr;
    v.ec = ec; v.ew = ew; v.ee = ee;
    vecs.push_back(v);
  endfunction

  function automatic stim_t rand_stim(input bit allow_lock);
    stim_t s;
    s.we   = ($urandom_range(0, 29) == 0);
    s.en   = ($urandom_range(0, 3) != 0);
    s.lk   = allow_lock && ($urandom_range(0, 99) == 0);
    s.tmo  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
    s.kick = ($urandom_range(0, 11) == 0);
    s.ce8  = ($urandom_range(0, 2) == 0);
    s.ce32 = ($urandom_range(0, 1) == 1);
    s.clr  = ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  function automatic stim_t mk(input bit we, input bit en, input bit lk, input bit [7:0] tmo,
                               input bit k, input bit c8, input bit c32, input bit clr);
    stim_t s;
    s.we = we; s.en = en; s.lk = lk; s.tmo = tmo;
    s.kick = k; s.ce8 = c8; s.ce32 = c32; s.clr = clr;
    return s;
  endfunction

  // Apply one cycle of stimulus, let the edge pass, advance the model.
  task automatic tick(input stim_t s);
    cfg_we = s.we; cfg_en = s.en; cfg_lock = s.lk; cfg_timeout = s.tmo;
    kick = s.kick; ce_8hz = s.ce8; ce_32khz = s.ce32; clr_expired = s.clr;
    @(posedge clk);
    #1;
    model_step(s);
  endtask

  task automatic tick_exp(input string name, input stim_t s, input bit [7:0] ec,
                          input bit ew, input bit ee);
    tick(s);
    $display("%s: count=%0d wdt_rst=%0b expired=%0b", name, count, wdt_rst, expired);
    check({name, " count"}, count, ec);
    check({name, " wdt_rst"}, {7'd0, wdt_rst}, {7'd0, ew});
    check({name, " expired"}, {7'd0, expired}, {7'd0, ee});
  endtask

  task automatic run_random(input int n, input bit allow_lock, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(rand_stim(allow_lock));
      check($sformatf("%s%0d count", tag, i), count, 8'(m_remaining));
      check($sformatf("%s%0d wdt_rst", tag, i), {7'd0, wdt_rst}, {7'd0, m_pulse_left > 0});
      check($sformatf("%s%0d expired", tag, i), {7'd0, expired}, {7'd0, m_expired});
    end
    $display("%s: %0d random cycles applied", tag, n);
  endtask

  initial begin
    stim_t idle_s;
    idle_s = mk(0, 0, 0, 8'd0, 0, 0, 0, 0);
    cfg_we = 0; cfg_en = 0; cfg_lock = 0; cfg_timeout = 8'd0;
    kick = 0; ce_8hz = 0; ce_32khz = 0; clr_expired = 0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset count", count, 8'd0);
    check("reset wdt_rst", {7'd0, wdt_rst}, 8'd0);
    check("reset expired", {7'd0, expired}, 8'd0);
    rst_n = 1'b1;

    //   we en lk tmo   k c8 c32 clr   count wdt exp
    add(1, 1, 0, 8'd3, 0, 0, 0, 0,   8'd0, 0, 0);
    add(0, 0, 0, 8'd0, 0, 0, 0, 0,   8'd3, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd2, 0, 0);
    add(0, 0, 0, 8'd0, 0, 0, 0, 0,   8'd2, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd1, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 1, 1, 0, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 0, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd3, 0, 1);
    add(0, 0, 0, 8'd0, 0, 0, 0, 1,   8'd3, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd2, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd1, 0, 0);
    add(0, 0, 0, 8'd0, 1, 1, 0, 0,   8'd3, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd2, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd1, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 1,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 0, 1,   8'd0, 1, 0);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 0);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 0);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 0);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd3, 0, 0);
    add(1, 1, 0, 8'd5, 0, 0, 0, 0,   8'd3, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd2, 0, 0);
    add(0, 0, 0, 8'd0, 1, 0, 0, 0,   8'd5, 0, 0);
    add(1, 0, 0, 8'd7, 0, 0, 0, 0,   8'd5, 0, 0);
    add(0, 0, 0, 8'd0, 1, 0, 0, 0,   8'd0, 0, 0);
    add(0, 0, 0, 8'd0, 0, 0, 0, 0,   8'd0, 0, 0);
    add(1, 1, 0, 8'd0, 0, 0, 0, 0,   8'd0, 0, 0);
    add(0, 0, 0, 8'd0, 0, 0, 0, 0,   8'd0, 0, 0);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd0, 1, 1);
    add(1, 0, 0, 8'd2, 0, 0, 0, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 1, 1);
    add(0, 0, 0, 8'd0, 0, 0, 1, 0,   8'd0, 0, 1);
    add(0, 0, 0, 8'd0, 0, 1, 0, 0,   8'd0, 0, 1);
    add(0, 0, 0, 8'd0, 0, 0, 0, 1,   8'd0, 0, 0);

    foreach (vecs[i]) begin
      tick_exp($sformatf("vec%0d", i), vecs[i].s, vecs[i].ec, vecs[i].ew, vecs[i].ee);
    end

    run_random(1500, 1'b0, "rndA");

    // Lock sequence, starting from a clean reset.
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick_exp("lock_wr",    mk(1, 1, 1, 8'd4, 0, 0, 0, 0), 8'd0, 0, 0);
    tick_exp("lock_start", idle_s,                         8'd4, 0, 0);
    tick_exp("lock_ce1",   mk(0, 0, 0, 8'd0, 0, 1, 0, 0), 8'd3, 0, 0);
    tick_exp("lock_clrwr", mk(1, 0, 0, 8'd5, 0, 0, 0, 0), 8'd3, 0, 0);
    tick_exp("lock_hold",  idle_s,                         8'd3, 0, 0);
    tick_exp("lock_ce2",   mk(0, 0, 0, 8'd0, 0, 1, 0, 0), 8'd2, 0, 0);
    tick_exp("lock_kick",  mk(0, 0, 0, 8'd0, 1, 0, 0, 0), 8'd5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick_exp($sformatf("lock_dn%0d", i), mk(0, 0, 0, 8'd0, 0, 1, 0, 0), 8'(4 - i), 0, 0);
    end
    tick_exp("lock_expire", mk(0, 0, 0, 8'd0, 0, 1, 0, 0), 8'd0, 1, 1);
    tick_exp("pulse_ce32",  mk(0, 0, 0, 8'd0, 0, 0, 1, 0), 8'd0, 1, 1);

    // Asynchronous reset in the middle of the pulse, between clock edges.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    $display("async_rst: count=%0d wdt_rst=%0b expired=%0b", count, wdt_rst, expired);
    check("async_rst count", count, 8'd0);
    check("async_rst wdt_rst", {7'd0, wdt_rst}, 8'd0);
    check("async_rst expired", {7'd0, expired}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick_exp("post_rst_idle", mk(0, 0, 0, 8'd0, 0, 1, 0, 0), 8'd0, 0, 0);
    tick_exp("post_rst_en",   mk(1, 1, 0, 8'd2, 0, 0, 0, 0), 8'd0, 0, 0);
    tick_exp("post_rst_cnt",  idle_s,                         8'd2, 0, 0);
    tick_exp("post_rst_dis",  mk(1, 0, 0, 8'd2, 0, 0, 0, 0), 8'd2, 0, 0);
    tick_exp("post_rst_unlk", idle_s,                         8'd0, 0, 0);

    run_random(1500, 1'b1, "rndB");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
